// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide/remainder, behind valid/ready on both sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_operation,
    input  logic [WIDTH-1:0] i_operand1,
    input  logic [WIDTH-1:0] i_operand2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IT_MUL = 2'd0,
        IT_DIV = 2'd1,
        IT_REM = 2'd2
    } iter_t;

    function automatic logic [WIDTH-1:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHAMT_W-1:0] sh;
        logic [WIDTH-1:0]   r;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned($signed(a) >>> sh);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    state_t           state_r, state_s;
    iter_t            kind_r, kind_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    // acc: product or partial remainder; aux: multiplicand or quotient/dividend; opb: multiplier or divisor
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] aux_r, aux_s;
    logic [WIDTH-1:0] opb_r, opb_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             zero_r;
    logic             valid_r;
    logic             load_s;

    logic [WIDTH-1:0] acc_step_s, aux_step_s, opb_step_s, iter_res_s;
    logic [WIDTH:0]   rem_sh_s;

    assign o_ready  = (state_r == ST_IDLE);
    assign o_valid  = valid_r;
    assign o_result = result_r;
    assign o_zero   = zero_r;

    // One multiply or divide iteration computed from the current accumulators
    always_comb begin
        acc_step_s = acc_r;
        aux_step_s = aux_r;
        opb_step_s = opb_r;
        rem_sh_s   = {acc_r, aux_r[WIDTH-1]};
        if (kind_r == IT_MUL) begin
            if (opb_r[0]) begin
                acc_step_s = acc_r + aux_r;
            end else begin
                acc_step_s = acc_r;
            end
            aux_step_s = aux_r << 1;
            opb_step_s = opb_r >> 1;
        end else begin
            // Divisor zero always "fits", giving all-ones quotient and remainder = dividend
            if (rem_sh_s >= {1'b0, opb_r}) begin
                acc_step_s = rem_sh_s[WIDTH-1:0] - opb_r;
                aux_step_s = {aux_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = rem_sh_s[WIDTH-1:0];
                aux_step_s = {aux_r[WIDTH-2:0], 1'b0};
            end
            opb_step_s = opb_r;
        end
        case (kind_r)
            IT_MUL:  iter_res_s = acc_step_s;
            IT_DIV:  iter_res_s = aux_step_s;
            IT_REM:  iter_res_s = acc_step_s;
            default: iter_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state, accumulator load/iterate and result capture
    always_comb begin
        state_s  = state_r;
        kind_s   = kind_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        aux_s    = aux_r;
        opb_s    = opb_r;
        result_s = result_r;
        load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    if ((i_operation == OP_MUL) || (i_operation == OP_DIVU) ||
                        (i_operation == OP_REMU)) begin
                        case (i_operation)
                            OP_MUL:  kind_s = IT_MUL;
                            OP_DIVU: kind_s = IT_DIV;
                            default: kind_s = IT_REM;
                        endcase
                        acc_s   = {WIDTH{1'b0}};
                        aux_s   = i_operand1;
                        opb_s   = i_operand2;
                        cnt_s   = CNT_W'(WIDTH);
                        state_s = ST_BUSY;
                    end else begin
                        result_s = single_op(i_operation, i_operand1, i_operand2);
                        load_s   = 1'b1;
                        state_s  = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_s = acc_step_s;
                aux_s = aux_step_s;
                opb_s = opb_step_s;
                cnt_s = cnt_r - CNT_W'(1);
                // Final iteration writes the result so latency is exactly WIDTH+1
                if (cnt_r <= CNT_W'(1)) begin
                    result_s = iter_res_s;
                    load_s   = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and iterative datapath registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            kind_r  <= IT_MUL;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            aux_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            kind_r  <= kind_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            aux_r   <= aux_s;
            opb_r   <= opb_s;
            valid_r <= (state_s == ST_DONE);
        end
    end

    // Result and zero flag, updated only on entry to DONE
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else if (load_s) begin
            result_r <= result_s;
            zero_r   <= (result_s == {WIDTH{1'b0}});
        end else begin
            result_r <= result_r;
            zero_r   <= zero_r;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc at WIDTH=32 with multi-cycle corner sequences.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_operation (op),
        .i_operand1  (a),
        .i_operand2  (b),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_result    (result),
        .o_zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one op with i_ready held high, then check latency, result, zero flag and return to IDLE
    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input logic exp_z,
                          input int lat);
        int n;
        @(negedge clk);
        check({nm, "_ready_before"}, {31'd0, out_ready}, 32'd1);
        in_ready = 1'b1;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'd1;
        a  = 32'hDEAD_BEEF;
        b  = 32'h0000_0003;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_valid || n >= 100) break;
        end
        check({nm, "_latency"}, n, lat);
        check({nm, "_result"}, result, exp);
        check({nm, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
        @(negedge clk);
        check({nm, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        in_valid = 1'b0;
        in_ready = 1'b0;
        op = 4'd0;
        a  = 32'd0;
        b  = 32'd0;
        rst_n = 1'b0;

        vecs.push_back('{"add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"sub",      4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1});
        vecs.push_back('{"xor",      4'd2,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1});
        vecs.push_back('{"or",       4'd3,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1});
        vecs.push_back('{"and",      4'd4,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1});
        vecs.push_back('{"sll",      4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1});
        vecs.push_back('{"srl",      4'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1});
        vecs.push_back('{"sra",      4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1});
        vecs.push_back('{"slt",      4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
        vecs.push_back('{"sltu",     4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"rsvd14",   4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"mul",      4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 33});
        vecs.push_back('{"mul_max",  4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33});
        vecs.push_back('{"divu",     4'd11, 32'd100,       32'd7,         32'd14,        1'b0, 33});
        vecs.push_back('{"remu",     4'd12, 32'd100,       32'd7,         32'd2,         1'b0, 33});
        vecs.push_back('{"divu_max", 4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33});
        vecs.push_back('{"divu_z",   4'd11, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33});
        vecs.push_back('{"remu_z",   4'd12, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 33});

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_ready = ~in_ready;
            op = 4'(i + 10);
            a  = $urandom;
            b  = $urandom;
        end
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, out_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        in_valid = 1'b0;
        in_ready = 1'b1;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid || !out_ready) seen++;
        end
        check("post_rst_idle", seen, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].exp_z, vecs[i].lat);
        end

        // Backpressure: result held, new request ignored, release on i_ready
        @(negedge clk);
        in_ready = 1'b0;
        in_valid = 1'b1;
        op = 4'd0;
        a  = 32'd20;
        b  = 32'd22;
        @(posedge clk);
        #1;
        op = 4'd1;
        a  = 32'd1;
        b  = 32'd9;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_valid || n >= 100) break;
        end
        check("bp_latency", n, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result !== 32'd42 || out_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        check("bp_hold", seen, 0);
        check("bp_result", result, 32'd42);
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_ready_back", {31'd0, out_ready}, 32'd1);
        check("bp_result_hold", result, 32'd42);

        // Reset in the middle of a DIVU abandons it
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd11;
        a  = 32'd1000;
        b  = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, out_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);
        run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute ALU.
- Generalises operand width and adds shifts, signed/unsigned compares, and iterative unsigned multiply, divide and remainder.
- Sits in the execute stage behind a valid/ready handshake on both the operand and result sides, so the core can stall on long operations.
- Single-cycle ops complete in one clock; MUL/DIVU/REMU take a fixed WIDTH+1 clocks.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of 2, ≥ 8.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from operand2 (derived; not overridden).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operand request valid.
- o_ready  out  1  block can accept a request.
- i_operation  in  4  op code: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 DIVU, 12 REMU; 13-15 reserved.
- i_operand1  in  WIDTH  first operand.
- i_operand2  in  WIDTH  second operand.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  result value.
- o_zero  out  1  o_result == 0; meaningful only while o_valid.

Behaviour:
- Reset: asynchronous assert on i_reset_n low; synchronous release.
  - State → IDLE, o_valid=0, o_result=0, o_zero=1, iteration counter=0, internal accumulators=0.
- Accept: occurs on a rising edge with i_valid && o_ready. o_ready = (state==IDLE), a combinational function of state only. Operands and op are captured on accept; later input changes are ignored.
- States:
  - IDLE: on accept of ops 0-9 or 13-15, compute the result and go to DONE. On accept of ops 10-12, load the accumulators, set counter=WIDTH and go to BUSY.
  - BUSY: one iteration per clock; counter decrements. When counter reaches 0, write the result and go to DONE.
  - DONE: o_valid=1 and o_result/o_zero are held stable. On i_ready, go to IDLE and drop o_valid. There is no accept in DONE, so back-to-back throughput is one op per 2 clocks minimum.
- Latency, measured from the accept edge to the first edge where o_valid=1:
  - 1 clock for ops 0-9 and reserved ops.
  - WIDTH+1 clocks for MUL/DIVU/REMU, independent of operand values.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - XOR/OR/AND are bitwise.
  - Shifts use operand2[SHAMT_W-1:0]; the upper bits are ignored. SRA replicates operand1[WIDTH-1].
  - SLT is signed and SLTU is unsigned; the result is zero-extended 0 or 1.
  - Reserved ops produce result 0 (o_zero=1).
- MUL: shift-add, one multiplier bit per clock, LSB first. Result is the low WIDTH bits of the unsigned product.
- DIVU/REMU: restoring division, one quotient bit per clock, MSB first. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: no exception and no early exit. DIVU returns all ones and REMU returns operand1; this falls out naturally from the restoring algorithm.
- o_result changes only on the transition into DONE; it holds its last value in IDLE/BUSY.
- i_valid while BUSY or DONE is ignored and not queued. The requester must hold it until o_ready.
- Reset mid-BUSY or mid-DONE abandons the operation; no result is emitted after release.
- i_ready asserted while o_valid=0 has no effect.

Test Plan:
- Reset: hold i_reset_n=0, toggle inputs → o_valid=0, o_ready=1, o_result=0, o_zero=1. Release mid-cycle → no output activity until the first accept.
- Single-cycle ops, WIDTH=32, each with i_ready=1:
  - ADD 0xFFFFFFFF+1 → 0, o_zero=1.
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000 by 0x24 (shamt 4) → 0xF8000000.
  - SLT -1,1 → 1.
  - SLTU -1,1 → 0.
  - op 14 → 0.
  - Each completes with o_valid exactly 1 clock after accept.
- Iterative ops, WIDTH=32:
  - MUL 0x10000 × 0x10001 → 0x00010000, o_valid exactly 33 clocks after accept.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234; both at 33 clocks.
- Backpressure: hold i_ready=0 for 10 clocks after o_valid → o_result stable, o_ready=0, a new i_valid is ignored. Raise i_ready → o_valid drops next edge and o_ready=1.
- Reset mid-operation: assert i_reset_n=0 at BUSY clock 12 of a DIVU, then release → o_valid never rises for that op. Next ADD 2+3 → 5 with normal latency.
